mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arb_select.sv | 38 +++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
//   WIDTH       : default address/data width
//   CNT_W       : width of the access-latency counter (LATENCY up to 7)
//   GNT_MEM/IF  : bit positions in the one-hot grant vector
//   arbState_e  : arbiter FSM states
//   reqId_e     : requester identifiers
package mem_arbiter_pkg;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned GNT_MEM = 0;
    localparam int unsigned GNT_IF  = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arbState_e;

    typedef enum logic {
        REQ_MEM = 1'b0,
        REQ_IF  = 1'b1
    } reqId_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the RAM.
//   MEM stage : memReq/memWe/memAddr/memWData in, memRData/memAck out
//   IF stage  : ifReq/ifAddr in, ifRData/ifAck out
//   RAM       : ramEn/ramWe/ramAddr/ramWData out, ramRData in
//   Stalls    : stallMEM/stallIF out (combinational)
// slave = arbiter side, master = requesters/RAM side.
interface mem_arbiter_if #(
    parameter int unsigned WIDTH = mem_arbiter_pkg::WIDTH
);

    logic             memReq;
    logic             memWe;
    logic [WIDTH-1:0] memAddr;
    logic [WIDTH-1:0] memWData;
    logic [WIDTH-1:0] memRData;
    logic             memAck;

    logic             ifReq;
    logic [WIDTH-1:0] ifAddr;
    logic [WIDTH-1:0] ifRData;
    logic             ifAck;

    logic             ramEn;
    logic             ramWe;
    logic [WIDTH-1:0] ramAddr;
    logic [WIDTH-1:0] ramWData;
    logic [WIDTH-1:0] ramRData;

    logic             stallMEM;
    logic             stallIF;

    modport slave (
        input  memReq, memWe, memAddr, memWData, ifReq, ifAddr, ramRData,
        output memRData, memAck, ifRData, ifAck,
               ramEn, ramWe, ramAddr, ramWData, stallMEM, stallIF
    );

    modport master (
        output memReq, memWe, memAddr, memWData, ifReq, ifAddr, ramRData,
        input  memRData, memAck, ifRData, ifAck,
               ramEn, ramWe, ramAddr, ramWData, stallMEM, stallIF
    );

endinterface

// File: rtl/mem_arb_select.sv
// Grant selection between the MEM and IF requesters.
//   memReq, ifReq : request levels
//   lastServed    : requester served last (only with MEM_ARB_RR_EN)
//   grant         : one-hot grant, bit GNT_MEM / GNT_IF, zero when idle
// Default build: fixed MEM priority. MEM_ARB_RR_EN: on a tie, the
// requester not served last wins.
module mem_arb_select
    import mem_arbiter_pkg::*;
(
    input  logic       memReq,
    input  logic       ifReq,
`ifdef MEM_ARB_RR_EN
    input  reqId_e     lastServed,
`endif
    output logic [1:0] grant
);

    // Tie-break first, then single-request cases.
    always_comb begin
        grant = 2'b00;
        if (memReq && ifReq) begin
`ifdef MEM_ARB_RR_EN
            if (lastServed == REQ_MEM) begin
                grant[GNT_IF] = 1'b1;
            end else begin
                grant[GNT_MEM] = 1'b1;
            end
`else
            grant[GNT_MEM] = 1'b1;
`endif
        end else if (memReq) begin
            grant[GNT_MEM] = 1'b1;
        end else if (ifReq) begin
            grant[GNT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port RAM between the MEM-stage load/store port and
// the IF-stage fetch port.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : mem_arbiter_if.slave (requests, responses, RAM side, stalls)
// Parameters: LATENCY (RAM access cycles, 1..7), WIDTH (addr/data width).
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-breaking;
// otherwise MEM has fixed priority and no pointer exists.
// Timing: request sampled in IDLE, RAM driven for LATENCY cycles, one RESP
// cycle, and the Ack pulse appears on the edge that leaves RESP, i.e.
// LATENCY+1 edges after sampling; one access per LATENCY+2 cycles.
module mem_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned WIDTH   = mem_arbiter_pkg::WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    import mem_arbiter_pkg::*;

    if (LATENCY < 1 || LATENCY > 7) begin : gLatencyCheck
        $error("mem_arbiter: LATENCY must be in 1..7");
    end

    arbState_e        state;
    reqId_e           granted;
    logic [CNT_W-1:0] count;
    logic [1:0]       grant;

    logic             ramEnQ;
    logic             ramWeQ;
    logic [WIDTH-1:0] ramAddrQ;
    logic [WIDTH-1:0] ramWDataQ;
    logic [WIDTH-1:0] memRDataQ;
    logic [WIDTH-1:0] ifRDataQ;
    logic             memAckQ;
    logic             ifAckQ;

`ifdef MEM_ARB_RR_EN
    reqId_e           lastServed;
`endif

    mem_arb_select uSelect (
        .memReq     (bus.memReq),
        .ifReq      (bus.ifReq),
`ifdef MEM_ARB_RR_EN
        .lastServed (lastServed),
`endif
        .grant      (grant)
    );

    // FSM, latency counter and all registered outputs.
    // ramAddr/ramWData/ramWe double as the latched request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            granted    <= REQ_MEM;
            count      <= '0;
            ramEnQ     <= 1'b0;
            ramWeQ     <= 1'b0;
            ramAddrQ   <= '0;
            ramWDataQ  <= '0;
            memRDataQ  <= '0;
            ifRDataQ   <= '0;
            memAckQ    <= 1'b0;
            ifAckQ     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            lastServed <= REQ_IF;
`endif
        end else begin
            memAckQ <= 1'b0;
            ifAckQ  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        count  <= CNT_W'(LATENCY - 1);
                        ramEnQ <= 1'b1;
                        state  <= ACCESS;
                        if (grant[GNT_IF]) begin
                            // Fetches are always reads.
                            granted    <= REQ_IF;
                            ramWeQ     <= 1'b0;
                            ramAddrQ   <= bus.ifAddr;
                            ramWDataQ  <= '0;
`ifdef MEM_ARB_RR_EN
                            lastServed <= REQ_IF;
`endif
                        end else begin
                            granted    <= REQ_MEM;
                            ramWeQ     <= bus.memWe;
                            ramAddrQ   <= bus.memAddr;
                            ramWDataQ  <= bus.memWData;
`ifdef MEM_ARB_RR_EN
                            lastServed <= REQ_MEM;
`endif
                        end
                    end
                end
                ACCESS: begin
                    if (count == '0) begin
                        ramEnQ <= 1'b0;
                        ramWeQ <= 1'b0;
                        state  <= RESP;
                        // Writes leave the RData registers untouched.
                        if (!ramWeQ) begin
                            if (granted == REQ_IF) begin
                                ifRDataQ <= bus.ramRData;
                            end else begin
                                memRDataQ <= bus.ramRData;
                            end
                        end
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (granted == REQ_IF) begin
                        ifAckQ <= 1'b1;
                    end else begin
                        memAckQ <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ramEn    = ramEnQ;
    assign bus.ramWe    = ramWeQ;
    assign bus.ramAddr  = ramAddrQ;
    assign bus.ramWData = ramWDataQ;
    assign bus.memRData = memRDataQ;
    assign bus.ifRData  = ifRDataQ;
    assign bus.memAck   = memAckQ;
    assign bus.ifAck    = ifAckQ;

    // Stall whoever is still waiting for its Ack.
    assign bus.stallMEM = bus.memReq & ~memAckQ;
    assign bus.stallIF  = bus.ifReq & ~ifAckQ;

endmodule
